tcm_receiver_capture_ctrl: RTL

Frame capture controller for the TCM receiver path. Consumes the 13-bit tagged word stream from the sync detector (`{wren, sof, eol/eof, data[9:0]}`) and turns it into a framed output stream of exactly `PIX_PER_LINE` × `LINES_PER_FRAME` words. Supports continuous and single-shot (armed) capture, geometry checking and overflow detection, with status reported to the register bank.

---
 rtl/tcm_receiver_capture_ctrl_if.sv | 19 +
 rtl/tcm_receiver_capture_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/tcm_receiver_capture_ctrl_if.sv
// Framed output stream of the TCM capture controller.
// The master drives data/valid/user/last and the slave drives ready.
interface tcm_receiver_capture_ctrl_if;
    logic [9:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tuser;
    logic       m_tlast;

    modport master (
        output m_tdata, m_tvalid, m_tuser, m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata, m_tvalid, m_tuser, m_tlast,
        output m_tready
    );
endinterface

// File: rtl/tcm_receiver_capture_ctrl.sv
// TCM receiver frame capture controller: turns the tagged word stream into
// fixed-geometry frames, with single-shot arming, length and overflow checks.
module tcm_receiver_capture_ctrl #(
    parameter int PIX_PER_LINE    = 1280,
    parameter int LINES_PER_FRAME = 1024,
    parameter int CW              = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] wdat,
    input  logic        cfg_enable,
    input  logic        cfg_single,
    input  logic        cfg_arm,
    input  logic        sts_clr,
    tcm_receiver_capture_ctrl_if.master m,
    output logic        sts_busy,
    output logic        sts_done,
    output logic [15:0] sts_frame_cnt,
    output logic        sts_err_len,
    output logic        sts_err_ovf
);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

    localparam logic [CW-1:0] PIX_N     = CW'(PIX_PER_LINE);
    localparam logic [CW-1:0] PIX_LAST  = CW'(PIX_PER_LINE - 1);
    localparam logic [CW-1:0] LINE_LAST = CW'(LINES_PER_FRAME - 1);

    state_t        state;
    logic [CW-1:0] pix;
    logic [CW-1:0] line;
    logic          vld_q;
    logic          arm_q;

    logic vld;
    logic sof;
    logic eol;
    logic stall;
    logic pix_full;
    logic unused_eol;

    assign vld        = wdat[12];
    assign sof        = wdat[11];
    assign unused_eol = wdat[10];
    assign eol        = vld_q & ~vld;
    assign stall      = m.m_tvalid & ~m.m_tready;
    assign pix_full   = (pix == PIX_N);
    assign sts_busy   = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pix           <= '0;
            line          <= '0;
            vld_q         <= 1'b0;
            arm_q         <= 1'b0;
            m.m_tdata     <= '0;
            m.m_tvalid    <= 1'b0;
            m.m_tuser     <= 1'b0;
            m.m_tlast     <= 1'b0;
            sts_done      <= 1'b0;
            sts_frame_cnt <= '0;
            sts_err_len   <= 1'b0;
            sts_err_ovf   <= 1'b0;
        end else begin
            vld_q    <= vld;
            sts_done <= 1'b0;
            if (cfg_arm)
                arm_q <= 1'b1;
            if (m.m_tready)
                m.m_tvalid <= 1'b0;
            // clear first so a same-cycle set below wins
            if (sts_clr) begin
                sts_err_len <= 1'b0;
                sts_err_ovf <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (cfg_enable && (!cfg_single || arm_q)) begin
                        state <= WAIT_SOF;
                        arm_q <= 1'b0;
                    end
                end
                WAIT_SOF: begin
                    if (!cfg_enable) begin
                        state <= IDLE;
                    end else if (vld && sof) begin
                        if (stall) begin
                            sts_err_ovf <= 1'b1;
                        end else begin
                            m.m_tdata  <= wdat[9:0];
                            m.m_tvalid <= 1'b1;
                            m.m_tuser  <= 1'b1;
                            m.m_tlast  <= 1'b0;
                            pix        <= CW'(1);
                            line       <= '0;
                            state      <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (vld) begin
                        if (stall && (sof || !pix_full)) begin
                            sts_err_ovf <= 1'b1;
                            state       <= WAIT_SOF;
                            arm_q       <= 1'b0;
                        end else if (sof) begin
                            // premature SOF restarts the frame in place
                            sts_err_len <= 1'b1;
                            m.m_tdata   <= wdat[9:0];
                            m.m_tvalid  <= 1'b1;
                            m.m_tuser   <= 1'b1;
                            m.m_tlast   <= 1'b0;
                            pix         <= CW'(1);
                            line        <= '0;
                        end else if (pix_full) begin
                            sts_err_len <= 1'b1;
                        end else begin
                            m.m_tdata  <= wdat[9:0];
                            m.m_tvalid <= 1'b1;
                            m.m_tuser  <= 1'b0;
                            m.m_tlast  <= (pix == PIX_LAST);
                            pix        <= pix + CW'(1);
                        end
                    end else if (eol) begin
                        if (!pix_full)
                            sts_err_len <= 1'b1;
                        pix <= '0;
                        if (line == LINE_LAST) begin
                            line          <= '0;
                            sts_done      <= 1'b1;
                            sts_frame_cnt <= sts_frame_cnt + 16'd1;
                            if (cfg_enable && !cfg_single) begin
                                state <= WAIT_SOF;
                                arm_q <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            line <= line + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
